seg_scan_driver: RTL

//  Receive end of the 4-digit display code bus (A,B,C,D 4-bit codes + blank mask) on the Basys3.

---
 rtl/seg_disp_pkg.sv | 32 +++
 rtl/seg_font_decode.sv | 32 +++
 rtl/seg_scan_driver.sv | 101 ++++++++++
 3 files changed

// File: rtl/seg_disp_pkg.sv
// Shared display constants: team font (active-high gfedcba), blanking values and
// the letter codes carried on the display code bus.
package seg_disp_pkg;

   localparam logic [6:0] FONT_0 = 7'h3F;
   localparam logic [6:0] FONT_1 = 7'h06;
   localparam logic [6:0] FONT_2 = 7'h5B;
   localparam logic [6:0] FONT_3 = 7'h4F;
   localparam logic [6:0] FONT_4 = 7'h66;
   localparam logic [6:0] FONT_5 = 7'h6D;
   localparam logic [6:0] FONT_6 = 7'h7D;
   localparam logic [6:0] FONT_7 = 7'h07;
   localparam logic [6:0] FONT_8 = 7'h7F;
   localparam logic [6:0] FONT_9 = 7'h6F;
   localparam logic [6:0] FONT_A = 7'h50;
   localparam logic [6:0] FONT_B = 7'h6D;
   localparam logic [6:0] FONT_C = 7'h5E;
   localparam logic [6:0] FONT_D = 7'h78;
   localparam logic [6:0] FONT_E = 7'h3D;
   localparam logic [6:0] FONT_F = 7'h6E;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   localparam logic [3:0] CODE_R = 4'hA;
   localparam logic [3:0] CODE_S = 4'hB;
   localparam logic [3:0] CODE_D = 4'hC;
   localparam logic [3:0] CODE_T = 4'hD;
   localparam logic [3:0] CODE_G = 4'hE;
   localparam logic [3:0] CODE_Y = 4'hF;

endpackage

// File: rtl/seg_font_decode.sv
// Combinational font lookup: 4-bit display code to active-high gfedcba pattern.
module seg_font_decode
   import seg_disp_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_pattern
);

   always_comb begin
      o_pattern = FONT_0;
      case (i_code)
         4'h0:   o_pattern = FONT_0;
         4'h1:   o_pattern = FONT_1;
         4'h2:   o_pattern = FONT_2;
         4'h3:   o_pattern = FONT_3;
         4'h4:   o_pattern = FONT_4;
         4'h5:   o_pattern = FONT_5;
         4'h6:   o_pattern = FONT_6;
         4'h7:   o_pattern = FONT_7;
         4'h8:   o_pattern = FONT_8;
         4'h9:   o_pattern = FONT_9;
         CODE_R: o_pattern = FONT_A;
         CODE_S: o_pattern = FONT_B;
         CODE_D: o_pattern = FONT_C;
         CODE_T: o_pattern = FONT_D;
         CODE_G: o_pattern = FONT_E;
         CODE_Y: o_pattern = FONT_F;
         default: o_pattern = FONT_0;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver: per-frame snapshot of the code bus, font
// decode and registered active-low anode/segment/dp drive at a fixed slot rate.
module seg_scan_driver
   import seg_disp_pkg::*;
#(
   parameter  int SCAN_DIV = 100000,
   localparam int PRE_W    = $clog2(SCAN_DIV)
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] C,
   input  logic [3:0] D,
   input  logic [3:0] blank,
   input  logic [3:0] dp_in,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   logic [PRE_W-1:0] r_pre;
   logic [1:0]       r_idx;
   logic [15:0]      r_codes;   // slot k code at [4k+3:4k]: D, C, B, A
   logic [3:0]       r_blank;
   logic [3:0]       r_dp_req;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;
   logic             r_frame_start;

   logic             w_tick;
   logic             w_snap;
   logic [1:0]       w_idx_nxt;
   logic [15:0]      w_codes_nxt;
   logic [3:0]       w_blank_nxt;
   logic [3:0]       w_dp_req_nxt;
   logic [3:0]       w_code_sel;
   logic [6:0]       w_pattern;

   assign w_tick       = en && (r_pre == PRE_W'(SCAN_DIV - 1));
   assign w_snap       = w_tick && (r_idx == 2'd3);
   assign w_idx_nxt    = r_idx + 2'd1;

   // Outputs of a tick edge use the snapshot taken on that same edge.
   assign w_codes_nxt  = w_snap ? {A, B, C, D} : r_codes;
   assign w_blank_nxt  = w_snap ? blank : r_blank;
   assign w_dp_req_nxt = w_snap ? dp_in : r_dp_req;
   assign w_code_sel   = w_codes_nxt[{w_idx_nxt, 2'b00} +: 4];

   seg_font_decode u_font (
      .i_code    (w_code_sel),
      .o_pattern (w_pattern)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre         <= '0;
         r_idx         <= 2'd0;
         r_codes       <= '0;
         r_blank       <= 4'b1111;
         r_dp_req      <= 4'b0000;
         r_an          <= AN_OFF;
         r_seg         <= SEG_OFF;
         r_dp          <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_snap;
         if (!en) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
         end else if (w_tick) begin
            r_pre    <= '0;
            r_idx    <= w_idx_nxt;
            r_codes  <= w_codes_nxt;
            r_blank  <= w_blank_nxt;
            r_dp_req <= w_dp_req_nxt;
            if (w_blank_nxt[w_idx_nxt]) begin
               r_an  <= AN_OFF;
               r_seg <= SEG_OFF;
               r_dp  <= 1'b1;
            end else begin
               r_an  <= ~(4'b0001 << w_idx_nxt);
               r_seg <= ~w_pattern;
               r_dp  <= ~w_dp_req_nxt[w_idx_nxt];
            end
         end else begin
            r_pre <= r_pre + 1'b1;
         end
      end
   end

   assign an          = r_an;
   assign seg         = r_seg;
   assign dp          = r_dp;
   assign frame_start = r_frame_start;

endmodule
